// File: rtl/clk_ctl.sv
// ----------------------------------------------------------------------------
// clk_ctl -- front-panel clock controller for a small CPU.
//
// Three asynchronous push buttons (go / step / halt) are synchronized and
// debounced. Each debounced rising edge becomes a one-cycle event that drives a
// four-state controller:
//   INIT : holds the CPU in reset for RST_CYC cycles, then moves to HALT
//   HALT : CPU frozen; go -> RUN, step -> STEP (halt has top priority)
//   RUN  : prescaler issues one ce pulse every DIV cycles until halt/HLT
//   STEP : exactly one ce pulse, then back to HALT
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   btn_go   in   asynchronous run button
//   btn_step in   asynchronous single-step button
//   btn_halt in   asynchronous halt button
//   halted   in   CPU executed HLT; only looked at in a ce cycle
//   ce       out  registered one-cycle CPU clock enable
//   rst_cpu  out  registered CPU reset, high in INIT
//   run      out  registered, high while in RUN
//   state    out  INIT=0, HALT=1, RUN=2, STEP=3
// ----------------------------------------------------------------------------
module clk_ctl #(
    parameter int DIV     = 1000,
    parameter int DEB     = 16,
    parameter int RST_CYC = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_go,
    input  logic       btn_step,
    input  logic       btn_halt,
    input  logic       halted,
    output logic       ce,
    output logic       rst_cpu,
    output logic       run,
    output logic [1:0] state
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
    localparam logic [7:0]    DEB_MAX  = 8'(DEB - 1);
    localparam logic [7:0]    INIT_MAX = 8'(RST_CYC - 1);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_HALT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_STEP = 2'd3;

    // Button bit order: [0]=go, [1]=step, [2]=halt
    localparam int EV_GO   = 0;
    localparam int EV_STEP = 1;
    localparam int EV_HALT = 2;

    logic [2:0]    btn_raw;
    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic [2:0]    deb_q, deb_d;
    logic [7:0]    dcnt_q [3];
    logic [7:0]    dcnt_d [3];
    logic [2:0]    ev_q, ev_d;

    logic [1:0]    state_q, state_d;
    logic          ce_q, ce_d;
    logic          run_q, run_d;
    logic          rst_cpu_q, rst_cpu_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    init_q, init_d;

    assign btn_raw = {btn_halt, btn_step, btn_go};

    // Synchronizer and debounce: the counter only advances while the
    // synchronized sample disagrees with the accepted level, so any sample
    // that agrees (a bounce) restarts the count from zero.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int i = 0; i < 3; i++) begin
            dcnt_d[i] = 8'd0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DEB_MAX) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 8'd1;
                end
            end
        end
        ev_d = deb_d & ~deb_q;
    end

    // Controller. Events arriving in INIT/STEP fall through unused, which is
    // what keeps them from being queued.
    always_comb begin
        state_d   = state_q;
        ce_d      = 1'b0;
        rst_cpu_d = 1'b0;
        presc_d   = presc_q;
        init_d    = init_q;
        case (state_q)
            S_INIT: begin
                rst_cpu_d = 1'b1;
                if (init_q == INIT_MAX) begin
                    state_d   = S_HALT;
                    rst_cpu_d = 1'b0;
                    init_d    = 8'd0;
                end else begin
                    init_d = init_q + 8'd1;
                end
            end
            S_HALT: begin
                if (ev_q[EV_HALT]) begin
                    state_d = S_HALT;
                end else if (ev_q[EV_STEP]) begin
                    // ce is raised together with entering STEP so the single
                    // pulse lines up with the STEP cycle.
                    state_d = S_STEP;
                    ce_d    = 1'b1;
                end else if (ev_q[EV_GO]) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end
            end
            S_RUN: begin
                // halted is meaningful only in the cycle the CPU was enabled.
                if (ev_q[EV_HALT] || (ce_q && halted)) begin
                    state_d = S_HALT;
                    presc_d = '0;
                end else if (presc_q == PRE_MAX) begin
                    ce_d    = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
        run_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            ev_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                dcnt_q[i] <= 8'd0;
            end
            state_q   <= S_INIT;
            ce_q      <= 1'b0;
            run_q     <= 1'b0;
            rst_cpu_q <= 1'b1;
            presc_q   <= '0;
            init_q    <= 8'd0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            ev_q      <= ev_d;
            for (int i = 0; i < 3; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
            state_q   <= state_d;
            ce_q      <= ce_d;
            run_q     <= run_d;
            rst_cpu_q <= rst_cpu_d;
            presc_q   <= presc_d;
            init_q    <= init_d;
        end
    end

    assign ce      = ce_q;
    assign rst_cpu = rst_cpu_q;
    assign run     = run_q;
    assign state   = state_q;

endmodule

// File: tb/tb_clk_ctl.sv
// ----------------------------------------------------------------------------
// tb_clk_ctl -- scoreboard bench for clk_ctl.
// Stimulus pushes one record per ce pulse it expects (state during the pulse
// and spacing from the previous pulse); an independent monitor pops a record
// on every observed ce pulse. A second instance runs with DIV=1.
// ----------------------------------------------------------------------------
module tb_clk_ctl;

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_HALT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_STEP = 2'd3;

    typedef struct {
        logic [1:0] st;
        int         gap;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       btn_go = 1'b0, btn_step = 1'b0, btn_halt = 1'b0, halted = 1'b0;
    logic       ce, rst_cpu, run;
    logic [1:0] state;

    logic       reset_b = 1'b1, go_b = 1'b0;
    logic       ce_b, rst_cpu_b, run_b;
    logic [1:0] state_b;

    clk_ctl #(.DIV(4), .DEB(16), .RST_CYC(8)) dut (
        .clk(clk), .reset(reset), .btn_go(btn_go), .btn_step(btn_step),
        .btn_halt(btn_halt), .halted(halted), .ce(ce), .rst_cpu(rst_cpu),
        .run(run), .state(state)
    );

    clk_ctl #(.DIV(1), .DEB(2), .RST_CYC(1)) dut_b (
        .clk(clk), .reset(reset_b), .btn_go(go_b), .btn_step(1'b0),
        .btn_halt(1'b0), .halted(1'b0), .ce(ce_b), .rst_cpu(rst_cpu_b),
        .run(run_b), .state(state_b)
    );

    int   nchk = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   last_ce = 0;
    int   ce_seen = 0;
    int   exp_total = 0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ce pulse consumes one expected record.
    always @(negedge clk) begin
        exp_t e;
        if (ce === 1'b1) begin
            ce_seen = ce_seen + 1;
            nchk = nchk + 1;
            if (exp_q.size() == 0) begin
                nfail = nfail + 1;
                $display("FAIL unexpected_ce: ce=1 at cycle %0d, required no pulse", cyc);
            end else begin
                e = exp_q.pop_front();
                if (state !== e.st) begin
                    nfail = nfail + 1;
                    $display("FAIL ce_state: state=%0d during ce, required %0d", state, e.st);
                end
                if (e.gap != 0) begin
                    nchk = nchk + 1;
                    if (cyc - last_ce != e.gap) begin
                        nfail = nfail + 1;
                        $display("FAIL ce_gap: spacing=%0d cycles, required %0d", cyc - last_ce, e.gap);
                    end
                end
            end
            last_ce = cyc;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        nchk = nchk + 1;
        if (act != exp) begin
            nfail = nfail + 1;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] st, input int gap);
        exp_t e;
        e.st  = st;
        e.gap = gap;
        exp_q.push_back(e);
        exp_total = exp_total + 1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state == s) begin
                found = 1'b1;
                break;
            end
        end
        chk(nm, int'(found), 1);
    endtask

    task automatic wait_ce(input int budget, input string nm);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ce === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk(nm, int'(found), 1);
    endtask

    // Watch the main DUT for n cycles, requiring it to stay in HALT;
    // the pressed buttons are dropped after rel cycles.
    task automatic hold_halt(input int n, input int rel, input string nm);
        bit bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (state != S_HALT) bad = 1'b1;
            if (i == rel) begin
                btn_go   = 1'b0;
                btn_step = 1'b0;
                btn_halt = 1'b0;
            end
        end
        chk(nm, int'(bad), 0);
    endtask

    initial begin
        int  n;
        bit  bad;

        // Reset state and INIT length
        tick(3);
        chk("reset_state", state, S_INIT);
        chk("reset_ce", ce, 0);
        chk("reset_run", run, 0);
        chk("reset_rst_cpu", rst_cpu, 1);
        reset   = 1'b0;
        reset_b = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rst_cpu) n++;
            else break;
        end
        chk("init_rst_cycles", n, 8);
        chk("init_to_halt", state, S_HALT);
        chk("init_ce", ce, 0);

        // Go held 20 cycles, run with ce every 4, halted at the 3rd ce
        push(S_RUN, 0);
        push(S_RUN, 4);
        push(S_RUN, 4);
        tick(1);
        btn_go = 1'b1;
        tick(20);
        btn_go = 1'b0;
        chk("go_state", state, S_RUN);
        chk("go_run", run, 1);
        wait_ce(40, "run_ce1");
        wait_ce(10, "run_ce2");
        wait_ce(10, "run_ce3");
        halted = 1'b1;
        @(posedge clk);
        #1;
        halted = 1'b0;
        chk("halted_state", state, S_HALT);
        chk("halted_run", run, 0);
        tick(30);
        chk("halted_ce_count", ce_seen, exp_total);

        // Bouncing go: no event
        for (int i = 0; i < 10; i++) begin
            btn_go = ~btn_go;
            tick(1);
        end
        btn_go = 1'b0;
        tick(30);
        chk("bounce_state", state, S_HALT);

        // Step held 200 cycles: one ce in STEP, then HALT
        push(S_STEP, 0);
        btn_step = 1'b1;
        wait_state(S_STEP, 40, "step_enter");
        chk("step_ce", ce, 1);
        @(negedge clk);
        chk("step_to_halt", state, S_HALT);
        chk("step_ce_off", ce, 0);
        tick(200);
        btn_step = 1'b0;
        tick(30);
        chk("step_ce_count", ce_seen, exp_total);

        // Halt+go together, then halt+step together
        btn_halt = 1'b1;
        btn_go   = 1'b1;
        hold_halt(60, 25, "halt_go_stay");
        btn_halt = 1'b1;
        btn_step = 1'b1;
        hold_halt(60, 25, "halt_step_stay");
        chk("halt_step_ce_count", ce_seen, exp_total);

        // Go while halted=1 still runs; stops at first ce
        halted = 1'b1;
        push(S_RUN, 0);
        btn_go = 1'b1;
        wait_state(S_RUN, 40, "go_halted_run");
        btn_go = 1'b0;
        wait_ce(10, "go_halted_ce");
        @(posedge clk);
        #1;
        halted = 1'b0;
        chk("go_halted_stop", state, S_HALT);
        tick(30);

        // Reset mid-RUN
        push(S_RUN, 0);
        btn_go = 1'b1;
        wait_state(S_RUN, 40, "rst_run_enter");
        btn_go = 1'b0;
        wait_ce(10, "rst_run_ce");
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_rst_state", state, S_INIT);
        chk("midrun_rst_ce", ce, 0);
        chk("midrun_rst_cpu", rst_cpu, 1);
        chk("midrun_rst_run", run, 0);
        tick(1);
        chk("midrun_rst_ce2", ce, 0);
        reset = 1'b0;
        wait_state(S_HALT, 20, "midrun_back_halt");
        tick(10);
        chk("final_ce_count", ce_seen, exp_total);
        chk("scoreboard_empty", exp_q.size(), 0);

        // DIV=1 instance: ce continuously high, reset drops it next edge
        go_b = 1'b1;
        bad  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (state_b == S_RUN) begin
                bad = 1'b0;
                break;
            end
        end
        chk("div1_enter_run", int'(bad), 0);
        go_b = 1'b0;
        tick(2);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ce_b !== 1'b1) bad = 1'b1;
        end
        chk("div1_ce_high", int'(bad), 0);
        tick(1);
        reset_b = 1'b1;
        tick(1);
        chk("div1_rst_ce", ce_b, 0);
        chk("div1_rst_cpu", rst_cpu_b, 1);
        chk("div1_rst_state", state_b, S_INIT);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/clk_ctl.md
CLK_CTL -- requirements
Module: clk_ctl

Interface
REQ-001 Parameter DIV, default 1000: number of clk cycles per run-mode clock-enable pulse, legal range 1..2^20.
REQ-002 Parameter DEB, default 16: number of consecutive stable samples a button needs before it is accepted, legal range 2..255.
REQ-003 Parameter RST_CYC, default 8: number of cycles rst_cpu is held after reset, legal range 1..255.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 btn_go  in  1  asynchronous run button, active-high.
REQ-007 btn_step  in  1  asynchronous single-step button, active-high.
REQ-008 btn_halt  in  1  asynchronous halt button, active-high.
REQ-009 halted  in  1  CPU has executed HLT, synchronous to clk; sampled when ce is high.
REQ-010 ce  out  1  one-cycle clock-enable pulse that advances the CPU by one cycle.
REQ-011 rst_cpu  out  1  synchronous reset to the CPU, active-high.
REQ-012 run  out  1  high while in state RUN.
REQ-013 state  out  2  current state: INIT=0, HALT=1, RUN=2, STEP=3.

Function
REQ-014 Each button passes through a 2-flip-flop synchronizer, then a debounce counter; the debounced level changes only after DEB consecutive equal synchronized samples.
REQ-015 A button event is a one-cycle pulse on the debounced rising edge; a held button generates exactly one event.
REQ-016 The states are INIT, HALT, RUN and STEP.
REQ-017 INIT: rst_cpu=1 and ce=0 for RST_CYC cycles, then go to HALT with rst_cpu=0.
REQ-018 HALT: ce=0. Go event goes to RUN with the prescaler cleared. Step event goes to STEP.
REQ-019 RUN: a prescaler counts 0..DIV-1 and asserts ce for one cycle when it reaches DIV-1, then wraps to 0. With DIV=1, ce stays high continuously.
REQ-020 RUN: a halt event, or halted=1 sampled in a ce cycle, goes to HALT on the next edge; no further ce is issued.
REQ-021 STEP: ce=1 for exactly one cycle, then HALT unconditionally.
REQ-022 Priority for simultaneous events: halt > step > go.
REQ-023 In RUN, step and go events are ignored. In STEP and INIT, all events are ignored and not queued.
REQ-024 Go while halted=1 still enters RUN; the halted input is only evaluated at the next ce.
REQ-025 The run output is registered and equals (state==RUN); ce is registered and never glitches.
REQ-026 The prescaler width is ceil(log2(DIV)) and the count saturates to no value outside 0..DIV-1.

Reset
REQ-027 When reset=1: state=INIT, ce=0, run=0, rst_cpu=1; prescaler, debounce counters, synchronizers and the INIT counter are cleared.
REQ-028 Reset asserted mid-RUN or mid-STEP aborts on the next edge; no ce is emitted in the reset cycle or the following one.
REQ-029 Reset has priority over every event and over halted.

Verification
REQ-030 Reset for 1 cycle with RST_CYC=8 -> rst_cpu high for exactly 8 cycles after release, then state=HALT(1), ce=0.
REQ-031 DEB=16, DIV=4; go pulse held 20 cycles -> state=RUN, run=1, ce pulses exactly every 4 cycles; button bouncing for 10 cycles causes no event.
REQ-032 Step event from HALT -> exactly one ce pulse, state goes 3 then 1; holding step for 200 cycles -> still one pulse.
REQ-033 RUN with DIV=4 and halted=1 at the 3rd ce -> state=HALT the next cycle, ce count stays at 3.
REQ-034 Halt and go debounced in the same cycle while in HALT -> remains in HALT; halt and step together -> no ce.
REQ-035 DIV=1 in RUN -> ce continuously high; reset asserted -> ce=0 and rst_cpu=1 on the next edge.
